lane_packer_2to8: RTL and testbench

Sequential packer that assembles a stream of 2-bit lane symbols into 8-bit words. It is the write-side counterpart of the team's 4:1 lane-select mux, which reads lane k from bits [2k+1:2k]. Symbols arrive on a valid/ready sink, fill lanes 0..3 in order, and leave as one registered word on a valid/ready source. It sits between a 2-bit symbol producer and any consumer of packed 8-bit lane vectors.

---
 rtl/lane_pkg.sv | 15 +
 rtl/lane_packer_2to8_if.sv | 35 +++
 rtl/lane_wr_decoder.sv | 19 +
 rtl/lane_packer_2to8.sv | 97 +++++++++
 tb/tb_lane_packer_2to8.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/lane_pkg.sv
// Shared lane geometry and types for the 2-bit lane packer and the lane-select mux.
// Both sides import this package so that lane k always sits at [k*LANE_W +: LANE_W].
package lane_pkg;

    localparam int LANE_W = 2;
    localparam int LANES  = 4;
    localparam int WORD_W = LANES * LANE_W;
    localparam int IDX_W  = $clog2(LANES);

    typedef logic [LANE_W-1:0] lane_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [IDX_W-1:0]  lane_idx_t;
    typedef logic [LANES-1:0]  lane_mask_t;

endpackage

// File: rtl/lane_packer_2to8_if.sv
// Symbol sink and packed-word source of lane_packer_2to8, bundled with master/slave modports.
// out_par exists only when LANE_PACKER_PARITY_EN is defined.
interface lane_packer_2to8_if
    import lane_pkg::*;
();

    logic      in_valid;
    logic      in_ready;
    lane_t     in_data;
    logic      in_last;
    logic      out_valid;
    logic      out_ready;
    word_t     out_data;
    lane_idx_t out_lanes;
`ifdef LANE_PACKER_PARITY_EN
    logic      out_par;
`endif

    modport master (
        output in_valid, in_data, in_last, out_ready,
`ifdef LANE_PACKER_PARITY_EN
        input  out_par,
`endif
        input  in_ready, out_valid, out_data, out_lanes
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
`ifdef LANE_PACKER_PARITY_EN
        output out_par,
`endif
        output in_ready, out_valid, out_data, out_lanes
    );

endinterface

// File: rtl/lane_wr_decoder.sv
// One-hot lane write enable from the lane index, gated by the accept strobe.
// Inverse of the lane-select mux: exactly one lane is written per accepted symbol.
module lane_wr_decoder
    import lane_pkg::*;
(
    input  logic       accept,
    input  lane_idx_t  idx,
    output lane_mask_t wr_en
);

    always_comb begin
        // NOTE: default every always_comb output first so no path can infer a latch.
        wr_en = '0;
        if (accept) begin
            wr_en[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/lane_packer_2to8.sv
// Packs 2-bit lane symbols into 8-bit words, lanes 0..3 in order, in_last closes a word early.
// Define LANE_PACKER_PARITY_EN to add a registered even-parity bit (out_par) on the output word.
module lane_packer_2to8
    import lane_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    lane_packer_2to8_if.slave  bus
);

    lane_idx_t  idx;
    word_t      asm_q;
    lane_mask_t wr_en;
    word_t      packed_word;
    logic       accept;
    logic       complete;
    logic       in_ready;
    logic       out_valid_q;
    word_t      out_data_q;
    lane_idx_t  out_lanes_q;

    // Ready only depends on the output slot, so a stalled word blocks every symbol.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign complete = accept && ((idx == lane_idx_t'(LANES - 1)) || bus.in_last);

    lane_wr_decoder u_wr_decoder (
        .accept (accept),
        .idx    (idx),
        .wr_en  (wr_en)
    );

    // Word as it would leave: assembly plus the incoming symbol, lanes above idx forced to 0.
    always_comb begin
        packed_word = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_idx_t'(k) <= idx) begin
                packed_word[k*LANE_W +: LANE_W] = wr_en[k] ? bus.in_data
                                                           : asm_q[k*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            idx   <= '0;
            asm_q <= '0;
        end else if (complete) begin
            idx   <= '0;
            asm_q <= '0;
        end else if (accept) begin
            idx <= idx + 1'b1;
            for (int k = 0; k < LANES; k++) begin
                if (wr_en[k]) begin
                    asm_q[k*LANE_W +: LANE_W] <= bus.in_data;
                end
            end
        end
    end

    // Completion reloads the slot even while it drains, so back-to-back words have no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_lanes_q <= '0;
        end else if (complete) begin
            out_valid_q <= 1'b1;
            out_data_q  <= packed_word;
            out_lanes_q <= idx;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef LANE_PACKER_PARITY_EN
    logic out_par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par_q <= 1'b0;
        end else if (complete) begin
            out_par_q <= ^packed_word;
        end
    end

    assign bus.out_par = out_par_q;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_lanes = out_lanes_q;

endmodule

// File: tb/tb_lane_packer_2to8.sv
// Self-checking bench for lane_packer_2to8: directed scenarios then random traffic
// against a symbol-accumulating reference model.
module tb_lane_packer_2to8;
    import lane_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    lane_packer_2to8_if bus ();

    lane_packer_2to8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int passes = 0;
    int checks = 0;

    // Reference model: words built by summing symbol << (LANE_W * position).
    int   m_acc;
    int   m_cnt;
    logic m_valid;
    int   m_word;
    int   m_lanes;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_acc   = 0;
        m_cnt   = 0;
        m_valid = 1'b0;
        m_word  = 0;
        m_lanes = 0;
    endtask

    task automatic check_out();
        check("out_valid", bus.out_valid, m_valid);
        check("out_data",  bus.out_data,  m_word);
        check("out_lanes", bus.out_lanes, m_lanes);
`ifdef LANE_PACKER_PARITY_EN
        check("out_par",   bus.out_par,   $countones(m_word) % 2);
`endif
    endtask

    // Called at posedge+1: drive, check ready at negedge, advance model at posedge, check outputs.
    task automatic cycle(input logic v, input int d, input logic l, input logic r);
        logic exp_ready;
        logic done;
        int   w;
        int   ln;
        bus.in_valid  = v;
        bus.in_data   = lane_t'(d);
        bus.in_last   = l;
        bus.out_ready = r;
        @(negedge clk);
        exp_ready = !m_valid || r;
        check("in_ready", bus.in_ready, exp_ready);
        done = 1'b0;
        w    = 0;
        ln   = 0;
        if (v && exp_ready) begin
            m_acc += (d & ((1 << LANE_W) - 1)) << (LANE_W * m_cnt);
            if (m_cnt == LANES - 1 || l) begin
                done  = 1'b1;
                w     = m_acc;
                ln    = m_cnt;
                m_acc = 0;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        if (done) begin
            m_valid = 1'b1;
            m_word  = w;
            m_lanes = ln;
        end else if (r) begin
            m_valid = 1'b0;
        end
        #1;
        check_out();
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    // Called at posedge+1: assert reset mid-cycle, check outputs clear at once, release away from edges.
    task automatic mid_cycle_reset();
        idle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data",  bus.out_data,  8'h00);
        check("rst_out_lanes", bus.out_lanes, 2'd0);
        check("rst_in_ready",  bus.in_ready,  1'b1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_out();
        check("reset_in_ready", bus.in_ready, 1'b1);

        // Full word 01,10,11,00 -> 8'h39, visible one cycle after the 4th accept.
        cycle(1'b1, 1, 1'b0, 1'b1);
        cycle(1'b1, 2, 1'b0, 1'b1);
        cycle(1'b1, 3, 1'b0, 1'b1);
        check("full_not_yet", bus.out_valid, 1'b0);
        cycle(1'b1, 0, 1'b0, 1'b1);
        check("full_valid", bus.out_valid, 1'b1);
        check("full_data",  bus.out_data,  8'h39);
        check("full_lanes", bus.out_lanes, 2'd3);
        cycle(1'b0, 0, 1'b0, 1'b1);
        check("full_pulse_end", bus.out_valid, 1'b0);

        // Early close on lane 0.
        cycle(1'b1, 3, 1'b1, 1'b1);
        check("early_data",  bus.out_data,  8'h03);
        check("early_lanes", bus.out_lanes, 2'd0);
        cycle(1'b0, 0, 1'b0, 1'b1);

        // Backpressure: word held, 4 symbols refused, then drained and a fresh word built from lane 0.
        cycle(1'b1, 1, 1'b0, 1'b0);
        cycle(1'b1, 2, 1'b0, 1'b0);
        cycle(1'b1, 3, 1'b0, 1'b0);
        cycle(1'b1, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, int'($urandom_range(3)), 1'b0, 1'b0);
            check("bp_refused", bus.in_ready, 1'b0);
            check("bp_hold",    bus.out_data, 8'h39);
        end
        cycle(1'b0, 0, 1'b0, 1'b1);
        check("bp_drained", bus.out_valid, 1'b0);
        cycle(1'b1, 2, 1'b0, 1'b1);
        cycle(1'b1, 1, 1'b0, 1'b1);
        cycle(1'b1, 0, 1'b0, 1'b1);
        cycle(1'b1, 3, 1'b0, 1'b1);
        check("bp_second_word", bus.out_data, 8'hC6);

        // Back-to-back: 8 symbols, two words with no bubble or lost symbol.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, int'($urandom_range(3)), 1'b0, 1'b1);
            if (i == 3 || i == 7) check("b2b_valid", bus.out_valid, 1'b1);
        end
        cycle(1'b0, 0, 1'b0, 1'b1);

        // Reset mid-word discards the partial assembly.
        cycle(1'b1, 1, 1'b0, 1'b1);
        cycle(1'b1, 2, 1'b0, 1'b1);
        mid_cycle_reset();
        cycle(1'b1, 3, 1'b0, 1'b1);
        cycle(1'b1, 3, 1'b0, 1'b1);
        cycle(1'b1, 3, 1'b0, 1'b1);
        cycle(1'b1, 3, 1'b0, 1'b1);
        check("post_reset_word",  bus.out_data,  8'hFF);
        check("post_reset_lanes", bus.out_lanes, 2'd3);

        // Random traffic: sparse valid, occasional in_last, frequent backpressure.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(3) != 0, int'($urandom_range(3)),
                  $urandom_range(7) == 0, $urandom_range(3) != 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
